// File: rtl/df4iah_board_core_if.sv
// Async SRAM pin bundle between the bring-up core and the 2Mx8 SRAM.
// The core only samples data; nothing on the core side can drive it.
interface df4iah_board_core_if;
    logic [3:0]  cs_n;
    logic        read_n;
    logic        write_n;
    logic [20:0] addr;
    logic [7:0]  data;

    modport master (output cs_n, output read_n, output write_n, output addr, input data);
    modport slave  (input cs_n, input read_n, input write_n, input addr, output data);
endinterface

// File: rtl/df4iah_board_core.sv
// DF4IAH_V3 bring-up core: heartbeat/status LEDs, read-only SRAM scan against an incrementing
// byte pattern, idle board interfaces. Comparator/flags built only when SRAM_CHECK_EN is defined.
module df4iah_board_core #(
    parameter int SRAM_WORDS     = 256,
    parameter int READ_CYCLES    = 4,
    parameter int HEARTBEAT_W    = 24,
    parameter int PHY_RST_CYCLES = 1000
) (
    input  logic                 i_brd_clk,
    input  logic                 i_reset,
    output logic [3:0]           o_led,
    output logic                 o_uart0_rx,
    output logic                 o_uart0_cts,
    output logic                 o_i2c0_scl,
    inout  wire                  io_i2c0_sda,
    output logic                 o_spi0_sclk,
    output logic                 o_spi0_mosi,
    output logic                 o_spi0_ss_n,
    df4iah_board_core_if.master  sram,
    output logic [3:0]           o_mtxd,
    output logic                 o_mtxen,
    output logic                 o_mtxerr,
    output logic                 o_mdc,
    inout  wire                  io_md,
    output logic                 o_phy_reset_n,
    output logic [2:0]           o_monitor
);
    localparam int IDX_W = (SRAM_WORDS > 1) ? $clog2(SRAM_WORDS) : 1;
    localparam int RC_W  = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam int PHY_W = $clog2(PHY_RST_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, READ, RECOVER} state_t;

    state_t               state, state_nxt;
    logic [RC_W-1:0]      rd_cnt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [7:0]           expected;
    logic [7:0]           captured;
    logic [HEARTBEAT_W-1:0] heartbeat;
    logic [PHY_W-1:0]     phy_cnt;
    logic [3:0]           cs_n;
    logic                 read_n;
    logic [20:0]          addr;
    logic                 last_read;
    logic                 wrap;
    logic                 error;
    logic                 pass;

    always_comb begin
        state_nxt = state;
        last_read = (state == READ) && (rd_cnt == RC_W'(READ_CYCLES - 1));
        wrap      = (idx == IDX_W'(SRAM_WORDS - 1));
        idx_nxt   = idx;
        case (state)
            IDLE:    state_nxt = SETUP;
            SETUP:   state_nxt = READ;
            READ:    if (last_read) state_nxt = RECOVER;
            RECOVER: begin
                state_nxt = SETUP;
                idx_nxt   = wrap ? '0 : idx + IDX_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pin-facing strobes are registered from the next state so the SRAM sees clean edges.
    always_ff @(posedge i_brd_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            idx       <= '0;
            expected  <= '0;
            captured  <= '0;
            heartbeat <= '0;
            phy_cnt   <= '0;
            cs_n      <= 4'hF;
            read_n    <= 1'b1;
            addr      <= '0;
        end else begin
            state     <= state_nxt;
            heartbeat <= heartbeat + HEARTBEAT_W'(1);
            if (phy_cnt != PHY_W'(PHY_RST_CYCLES))
                phy_cnt <= phy_cnt + PHY_W'(1);
            rd_cnt    <= (state == READ && !last_read) ? rd_cnt + RC_W'(1) : '0;
            if (last_read)
                captured <= sram.data;
            if (state == RECOVER)
                expected <= expected + 8'd1;
            idx       <= idx_nxt;
            cs_n      <= {3'b111, !(state_nxt == SETUP || state_nxt == READ)};
            read_n    <= !(state_nxt == READ);
            if (state_nxt == SETUP)
                addr <= 21'(idx_nxt);
        end
    end

`ifdef SRAM_CHECK_EN
    logic mismatch;
    assign mismatch = (captured != expected);

    // Pass only counts a full pass in which neither earlier accesses nor this last one failed.
    always_ff @(posedge i_brd_clk) begin
        if (i_reset) begin
            error <= 1'b0;
            pass  <= 1'b0;
        end else if (state == RECOVER) begin
            if (mismatch)
                error <= 1'b1;
            if (wrap && !error && !mismatch)
                pass <= 1'b1;
        end
    end
`else
    logic unused_check;
    assign unused_check = ^{captured, expected};
    assign error = 1'b0;
    assign pass  = 1'b0;
`endif

    assign sram.cs_n     = cs_n;
    assign sram.read_n   = read_n;
    assign sram.write_n  = 1'b1;
    assign sram.addr     = addr;

    assign o_led         = {state != IDLE, error, pass, heartbeat[HEARTBEAT_W-1]};
    assign o_monitor     = {error, ~read_n, ~cs_n[0]};
    assign o_phy_reset_n = (phy_cnt == PHY_W'(PHY_RST_CYCLES));

    assign o_uart0_rx    = 1'b1;
    assign o_uart0_cts   = 1'b0;
    assign o_i2c0_scl    = 1'b1;
    assign io_i2c0_sda   = 1'bz;
    assign o_spi0_sclk   = 1'b0;
    assign o_spi0_mosi   = 1'b0;
    assign o_spi0_ss_n   = 1'b1;
    assign o_mtxd        = 4'h0;
    assign o_mtxen       = 1'b0;
    assign o_mtxerr      = 1'b0;
    assign o_mdc         = 1'b0;
    assign io_md         = 1'bz;
endmodule

// File: tb/tb_df4iah_board_core.sv
// Cycle-indexed reference model of the scan timeline plus a pattern-returning SRAM model.
module tb_df4iah_board_core;
    localparam int WORDS   = 256;
    localparam int RDC     = 4;
    localparam int PERIOD  = RDC + 2;
    localparam int HB_W    = 6;
    localparam int PHY_CYC = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #25 clk = ~clk;

    logic [3:0] led;
    logic       uart_rx, uart_cts, i2c_scl, spi_sclk, spi_mosi, spi_ss_n;
    logic [3:0] mtxd;
    logic       mtxen, mtxerr, mdc, phy_reset_n;
    logic [2:0] monitor;
    wire        sda, md;
    logic       sda_val = 1'b0;
    logic       md_val  = 1'b0;
    assign sda = sda_val;
    assign md  = md_val;

    df4iah_board_core_if bus ();
    logic [7:0] sram_dat = 8'h00;
    assign bus.data = sram_dat;

    df4iah_board_core #(.HEARTBEAT_W(HB_W)) dut (
        .i_brd_clk     (clk),
        .i_reset       (rst),
        .o_led         (led),
        .o_uart0_rx    (uart_rx),
        .o_uart0_cts   (uart_cts),
        .o_i2c0_scl    (i2c_scl),
        .io_i2c0_sda   (sda),
        .o_spi0_sclk   (spi_sclk),
        .o_spi0_mosi   (spi_mosi),
        .o_spi0_ss_n   (spi_ss_n),
        .sram          (bus),
        .o_mtxd        (mtxd),
        .o_mtxen       (mtxen),
        .o_mtxerr      (mtxerr),
        .o_mdc         (mdc),
        .io_md         (md),
        .o_phy_reset_n (phy_reset_n),
        .o_monitor     (monitor)
    );

    int         n_pass = 0;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         bad_j  = -1;
    logic [7:0] bad_val = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n = clock edges since reset released; access k occupies edges PERIOD*k+1 .. PERIOD*k+PERIOD
    function automatic bit err_at(int n);
`ifdef SRAM_CHECK_EN
        return (bad_j >= 0) && (n >= PERIOD * (bad_j + 1) + 1);
`else
        return (n < 0);
`endif
    endfunction

    function automatic bit pass_at(int n);
`ifdef SRAM_CHECK_EN
        return (n >= PERIOD * WORDS + 1) && (bad_j < 0 || bad_j >= WORDS);
`else
        return (n < 0);
`endif
    endfunction

    task automatic check_cycle(input int n, input bit in_reset);
        logic [3:0]  e_cs;
        logic        e_rd, e_busy, e_hb, e_phy, e_err, e_pass;
        logic [20:0] e_addr;
        int          p, k;
        if (in_reset || n == 0) begin
            e_cs = 4'hF; e_rd = 1'b1; e_addr = '0; e_busy = 1'b0;
            e_hb = 1'b0; e_phy = 1'b0; e_err = 1'b0; e_pass = 1'b0;
        end else begin
            p      = (n - 1) % PERIOD;
            k      = (n - 1) / PERIOD;
            e_cs   = (p <= RDC) ? 4'hE : 4'hF;
            e_rd   = (p >= 1 && p <= RDC) ? 1'b0 : 1'b1;
            e_addr = 21'(k % WORDS);
            e_busy = 1'b1;
            e_hb   = ((n % (1 << HB_W)) >= (1 << (HB_W - 1)));
            e_phy  = (n >= PHY_CYC);
            e_err  = err_at(n);
            e_pass = pass_at(n);
        end
        chk("led",          32'(led),         32'({e_busy, e_err, e_pass, e_hb}));
        chk("sram_cs_n",    32'(bus.cs_n),    32'(e_cs));
        chk("sram_read_n",  32'(bus.read_n),  32'(e_rd));
        chk("sram_addr",    32'(bus.addr),    32'(e_addr));
        chk("sram_write_n", 32'(bus.write_n), 32'd1);
        chk("phy_reset_n",  32'(phy_reset_n), 32'(e_phy));
        chk("monitor",      32'(monitor),     32'({e_err, ~e_rd, ~e_cs[0]}));
        chk("idle_pins", 32'({uart_rx, uart_cts, i2c_scl, spi_sclk, spi_mosi, spi_ss_n,
                              mtxd, mtxen, mtxerr, mdc}), 32'(13'b1_0_1_0_0_1_0000_0_0_0));
        chk("i2c0_sda",     32'(sda),         32'(sda_val));
        chk("md",           32'(md),          32'(md_val));
    endtask

    // SRAM model: valid byte only late in the read pulse, complemented garbage elsewhere.
    task automatic drive(input int n);
        int         p, k;
        logic [7:0] v;
        if (n >= 1) begin
            p = (n - 1) % PERIOD;
            k = (n - 1) / PERIOD;
            v = (k == bad_j) ? bad_val : 8'(k);
            sram_dat = (p >= 2 && p <= RDC) ? v : ~v;
        end else begin
            sram_dat = 8'($urandom);
        end
        sda_val = 1'($urandom);
        md_val  = 1'($urandom);
    endtask

    task automatic run(input int j, input logic [7:0] v, input int cycles);
        bad_j   = j;
        bad_val = v;
        rst     = 1'b0;
        drive(0);
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(n, 1'b0);
            drive(n);
        end
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(0, 1'b1);
            drive(0);
        end
    endtask

    initial begin
        int         j, cyc;
        logic [7:0] v;
        drive(0);
        hold_reset(20);
        // Clean full pass; 1600 ends inside READ so the next reset lands mid-access.
        run(-1, 8'h00, 1600);
        hold_reset(3);
        run(3, 8'h55, 1700);
        hold_reset(2);
        j   = int'($urandom_range(0, 60));
        v   = 8'(j) ^ 8'($urandom_range(1, 255));
        cyc = 1 + PERIOD * int'($urandom_range(j + 2, j + 30)) + int'($urandom_range(1, RDC));
        run(j, v, cyc);
        hold_reset(2);
        run(-1, 8'h00, 40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
